button_frame_sync: RTL
======================

Name: button_frame_sync

Overview:
Input-side counterpart to the frame-rate game loop: conditions the raw up/down push-buttons and presents them to the processor's IO inputs, changing only on the 60 Hz screen_end strobe. Each button press becomes exactly one frame-long io_jump pulse, so the processor never misses or double-counts a press. The block sits between the board button pins and the processor/VGA IO inputs in the top-level wrapper.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronized input must differ from its stable value before the stable value changes (10 ms at 100 MHz); legal values are 2 and above.
SYNC_STAGES, 2, flip-flop stages in each button synchronizer; legal values are 2 and above.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; state clears while reset is 0.
up_raw  input  1  raw, asynchronous, bouncy up button.
down_raw  input  1  raw, asynchronous, bouncy down button.
screen_end  input  1  single-cycle frame strobe from the VGA controller.
io_jump  output  1  high for exactly one frame after a captured up press.
io_down  output  1  debounced down level, sampled once per frame.
up_level  output  1  debounced up level, unsampled (debug).
jump_pending  output  1  up press captured and not yet presented.
coalesced_count  output  8  saturating count of up presses merged into an already-pending press.

Behaviour:
- Reset (reset=0, asynchronous): every synchronizer stage, stable value, debounce counter, io_jump, io_down, up_level, jump_pending and coalesced_count go to 0. Reset deassertion takes effect on the next rising edge.
- Synchronizer: one SYNC_STAGES-deep flop chain per button. Only the last stage (sync_x) feeds any logic.
- Debounce (per button): the counter width is clog2(DEBOUNCE_CYCLES).
  - If sync_x equals stable_x, the counter goes to 0.
  - Otherwise the counter increments.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and sync_x still differs, stable_x takes sync_x and the counter goes to 0.
  - A level held at the raw pin therefore changes stable_x SYNC_STAGES+DEBOUNCE_CYCLES edges after it first appears.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles is ignored.
- up_level equals stable_up.
- Press event: rise is true on the edge where stable_up changes from 0 to 1. Releases generate no event.
- Frame update on an edge with screen_end=1:
  - io_jump takes the jump_pending value from before that edge.
  - io_down takes stable_down.
  - jump_pending takes rise (a press on the same edge is kept for the next frame, not lost).
  - io_jump and io_down hold their values until the next screen_end.
- On an edge with screen_end=0:
  - If rise and jump_pending are both 1, coalesced_count increments and saturates at 255.
  - Otherwise, if rise is 1, jump_pending sets to 1.
  - When rise is 1 and jump_pending is already 1, jump_pending stays 1.
- A screen_end high for more than one cycle is treated as multiple frame edges. No filtering is applied; the upstream VGA controller guarantees single-cycle strobes.
- Button held through reset: after deassertion stable_up starts at 0. A held button therefore produces one fresh press event after SYNC_STAGES+DEBOUNCE_CYCLES edges. This is intended.
- Reset mid-debounce discards partial counts. Reset mid-frame clears io_jump immediately.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, SYNC_STAGES=2.)
1. Bounce rejection: up_raw toggles every 3 cycles for 30 cycles, then returns to 0 -> up_level, jump_pending and io_jump stay 0; coalesced_count=0.
2. Clean press: up_raw=1 from cycle 10 -> up_level=1 and jump_pending=1 six edges later. screen_end pulse at cycle 40 -> io_jump=1 and jump_pending=0 after that edge. Next screen_end at cycle 80 -> io_jump=0.
3. Coalescing: two clean presses (each held 10 cycles, separated by 10 low cycles) before one screen_end -> a single io_jump frame and coalesced_count=1. Repeat 300 times -> coalesced_count saturates at 255.
4. Coincident press and frame: rise occurs on the same edge as screen_end with nothing pending -> io_jump=0 and jump_pending=1 after that edge. Next screen_end -> io_jump=1 for one frame.
5. Down level: down_raw held 1 -> io_down=1 after the first screen_end following debounce. down_raw released -> io_down=0 at the first screen_end after 6 edges, and not before.
6. Async reset: drive reset=0 mid-frame with io_jump=1 and up_raw held 1 -> all outputs 0 without a clock edge. Release reset -> jump_pending=1 six edges later; the next screen_end gives io_jump=1.

Source files
------------

// File: rtl/button_frame_sync.sv
// button_frame_sync: synchronizes and debounces the up/down push-buttons and
// presents them to the processor IO inputs, changing only on the frame strobe.
// Each debounced up press becomes exactly one frame-long io_jump pulse; extra
// presses inside one frame are merged and counted in coalesced_count.
module button_frame_sync #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       up_raw,
    input  logic       down_raw,
    input  logic       screen_end,
    output logic       io_jump,
    output logic       io_down,
    output logic       up_level,
    output logic       jump_pending,
    output logic [7:0] coalesced_count
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_up_sync;
    logic [SYNC_STAGES-1:0] r_dn_sync;
    logic [CNT_W-1:0]       r_up_cnt;
    logic [CNT_W-1:0]       r_dn_cnt;
    logic                   r_up_stable;
    logic                   r_dn_stable;
    logic                   r_io_jump;
    logic                   r_io_down;
    logic                   r_jump_pending;
    logic [7:0]             r_coal;

    logic w_up_sync;
    logic w_dn_sync;
    logic w_up_flip;
    logic w_dn_flip;
    logic w_rise;

    assign w_up_sync = r_up_sync[SYNC_STAGES-1];
    assign w_dn_sync = r_dn_sync[SYNC_STAGES-1];

    // A flip happens once the synchronized level has disagreed for the full window
    assign w_up_flip = (w_up_sync != r_up_stable) && (r_up_cnt == CNT_LAST);
    assign w_dn_flip = (w_dn_sync != r_dn_stable) && (r_dn_cnt == CNT_LAST);

    // Press event: stable_up is about to go 0 -> 1 on this edge
    assign w_rise = w_up_flip && w_up_sync;

    // Metastability synchronizers for both raw buttons
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_up_sync <= '0;
            r_dn_sync <= '0;
        end else begin
            r_up_sync <= {r_up_sync[SYNC_STAGES-2:0], up_raw};
            r_dn_sync <= {r_dn_sync[SYNC_STAGES-2:0], down_raw};
        end
    end

    // Up-button debouncer: counts consecutive disagreeing cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_up_cnt    <= '0;
            r_up_stable <= 1'b0;
        end else if (w_up_sync == r_up_stable) begin
            r_up_cnt <= '0;
        end else if (w_up_flip) begin
            r_up_stable <= w_up_sync;
            r_up_cnt    <= '0;
        end else begin
            r_up_cnt <= r_up_cnt + CNT_W'(1);
        end
    end

    // Down-button debouncer: same scheme as the up button
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dn_cnt    <= '0;
            r_dn_stable <= 1'b0;
        end else if (w_dn_sync == r_dn_stable) begin
            r_dn_cnt <= '0;
        end else if (w_dn_flip) begin
            r_dn_stable <= w_dn_sync;
            r_dn_cnt    <= '0;
        end else begin
            r_dn_cnt <= r_dn_cnt + CNT_W'(1);
        end
    end

    // Frame-aligned presentation; a press on the frame edge rolls into the next frame
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_io_jump      <= 1'b0;
            r_io_down      <= 1'b0;
            r_jump_pending <= 1'b0;
            r_coal         <= 8'd0;
        end else if (screen_end) begin
            r_io_jump      <= r_jump_pending;
            r_io_down      <= r_dn_stable;
            r_jump_pending <= w_rise;
        end else if (w_rise) begin
            if (r_jump_pending) begin
                if (r_coal != 8'hFF) begin
                    r_coal <= r_coal + 8'd1;
                end
            end else begin
                r_jump_pending <= 1'b1;
            end
        end
    end

    assign io_jump         = r_io_jump;
    assign io_down         = r_io_down;
    assign up_level        = r_up_stable;
    assign jump_pending    = r_jump_pending;
    assign coalesced_count = r_coal;

endmodule
